csr_neighbor_fetch: RTL
=======================

// Module: csr_neighbor_fetch
// PURPOSE
// - Takes one vertex ID and streams out all of its neighbour IDs.
// - The graph is stored as CSR: a row-pointer table and an edge table, both held in graph_memory.
// - Sits directly upstream of graph_memory: drives its idx/data address ports, consumes rowidx_out/data_outa/data_outb.
// - Feeds the per-processor traversal engine through a valid/ready neighbour stream.
// PARAMETERS
// - PROC_BITS   4  width of the processor tag in the top bits of every memory address
// - PROC_ID     0  tag value driven on address bits [31+PROC_BITS:32]
// - MEM_LAT     2  graph_memory read latency in cycles (address+valid at t -> data at t+MEM_LAT)
// - FIFO_DEPTH  8  neighbour output buffer entries; must be >= 2*MEM_LAT+2
// PORTS
// - clk_in           in   1             system clock
// - rst_in           in   1             synchronous active-high reset
// - vtx_in           in   32            vertex ID to expand
// - vtx_valid_in     in   1             vtx_in valid
// - vtx_ready_out    out  1             high only in IDLE; handshake = valid&&ready
// - idx_addr         out  32+PROC_BITS  row-pointer read address {PROC_ID, ptr}
// - idx_validin      out  1             row-pointer read strobe
// - rowidx_out       in   32            row-pointer read data
// - data_addra/b     out  32+PROC_BITS  edge-table read addresses, ports A/B
// - data_validina/b  out  1             edge-table read strobes
// - data_outa/b      in   32            edge-table read data
// - nbr_out          out  32            neighbour ID
// - nbr_valid_out    out  1             nbr_out valid
// - nbr_ready_in     in   1             consumer ready
// - nbr_last_out     out  1             marks the final neighbour of the current vertex
// - done_out         out  1             1-cycle pulse when the vertex is fully expanded
// - degree_out       out  32            degree of the current vertex; held until the next accept
// BEHAVIOUR
// - Reset: all outputs are 0 except vtx_ready_out=1. FSM=IDLE, FIFO empty, in-flight count 0.
// - Read data timing: data returned by graph_memory is sampled exactly MEM_LAT cycles after its strobe, using an internal delay line. The memory's own valid outputs are not used.
// - IDLE: on accept, latch v. Go to PTR: issue idx_addr=v (cycle t) and idx_addr=v+1 (t+1).
// - PTR_WAIT: capture start=rowidx at t+MEM_LAT and end at t+1+MEM_LAT.
//   - degree = end-start, 32-bit unsigned, modulo 2^32.
//   - Then go to STREAM with e=start.
// - STREAM: each cycle, with free = FIFO_DEPTH - occupancy - inflight:
//   - remaining>=2 and free>=2: issue A=e, B=e+1; e+=2.
//   - remaining==1 and free>=1: issue A only; data_validinb=0.
//   - Otherwise issue nothing.
// - FIFO write order: returning data is written A before B in the same cycle, so output order is strictly ascending edge index.
// - Output stream: nbr_valid_out=!fifo_empty. A word pops when valid&&ready.
//   - nbr_last_out is high with the last word of the vertex.
//   - nbr_out holds stable while valid&&!ready.
// - DONE: entered when all edges are issued, inflight==0 and the last word has popped.
//   - done_out pulses for 1 cycle, then the FSM returns to IDLE.
// - degree==0: no edge reads are issued. done_out pulses at t+MEM_LAT+2; no nbr beat, no last.
// - Strobes: idx_validin and data_validin* are high only in cycles that issue. Addresses hold their value otherwise.
// - Reset mid-operation: abandon the vertex, flush the FIFO and delay line, and ignore any late memory data.
// - FIFO full with ready low: issuing stalls. No entry is ever dropped or overwritten.
// CONFIGURATION
// - NBR_FETCH_BOUNDS_CHECK_EN defined:
//   - if end<start, force degree=0 and pulse done_out.
//   - also add port err_out (out, 1): sticky, set on that event, cleared only by rst_in.
// - Not defined: no err_out port. Degree wraps per the modulo rule and streaming proceeds with the wrapped count.
// TESTING
// - v=3, ptr[3]=10, ptr[4]=14, ready=1: nbr=edge[10..13] in order; last on the 4th beat; done 1 cycle after; degree_out=4.
// - v=5, ptr[5]=ptr[6]=20: no data strobes; done pulse at 4 cycles after ptr issue; no nbr_valid.
// - Odd degree 3 (ptr 7->10): pair strobe A=7/B=8, then A=9 with data_validinb=0; 3 beats in order.
// - Degree 20 with nbr_ready_in low for 30 cycles: occupancy plus inflight never exceeds 8; after release, all 20 arrive with none lost or duplicated.
// - rst_in pulsed mid-STREAM of degree 16: next cycle nbr_valid_out=0 and vtx_ready_out=1; the next vertex streams cleanly.
// - ptr 30->25 with NBR_FETCH_BOUNDS_CHECK_EN: err_out=1, done pulse, 0 beats.

Source files
------------

// File: rtl/csr_neighbor_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : csr_neighbor_fetch
//  Purpose  : Expands one vertex of a CSR graph into a valid/ready stream of
//             its neighbour IDs. Reads the row-pointer pair, then fetches
//             edge words two at a time through graph_memory ports A/B and
//             buffers them in a small output FIFO.
//  Options  : NBR_FETCH_BOUNDS_CHECK_EN - treats end<start as an empty row
//             and raises the sticky err_out flag.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_neighbor_fetch #(
    parameter int PROC_BITS  = 4,
    parameter int PROC_ID    = 0,
    parameter int MEM_LAT    = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [31:0]            vtx_in,
    input  logic                   vtx_valid_in,
    output logic                   vtx_ready_out,
    output logic [32+PROC_BITS-1:0] idx_addr,
    output logic                   idx_validin,
    input  logic [31:0]            rowidx_out,
    output logic [32+PROC_BITS-1:0] data_addra,
    output logic [32+PROC_BITS-1:0] data_addrb,
    output logic                   data_validina,
    output logic                   data_validinb,
    input  logic [31:0]            data_outa,
    input  logic [31:0]            data_outb,
    output logic [31:0]            nbr_out,
    output logic                   nbr_valid_out,
    input  logic                   nbr_ready_in,
    output logic                   nbr_last_out,
    output logic                   done_out,
    output logic [31:0]            degree_out
`ifdef NBR_FETCH_BOUNDS_CHECK_EN
    ,
    output logic                   err_out
`endif
);

    localparam int c_AW = 32 + PROC_BITS;
    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PROC_BITS-1:0] c_TAG = PROC_BITS'(PROC_ID);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_PTR0     = 3'd1;
    localparam logic [2:0] c_PTR1     = 3'd2;
    localparam logic [2:0] c_PTR_WAIT = 3'd3;
    localparam logic [2:0] c_STREAM   = 3'd4;
    localparam logic [2:0] c_DONE     = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [31:0]     vtx_q;
    logic            got_start_q;
    logic [31:0]     start_q;
    logic [31:0]     degree_q;
    logic [31:0]     rem_q;
    logic [31:0]     e_q;
    logic [c_CW-1:0] inflight_q;
    logic [c_CW-1:0] count_q;
    logic [c_PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [MEM_LAT-1:0] idx_pipe_q, a_pipe_q, b_pipe_q, la_pipe_q, lb_pipe_q;
    logic [32:0]     fifo_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] idx_addr_q, addra_q, addrb_q;

    logic            w_idx_tap, w_a_tap, w_b_tap;
    logic            w_pop;
    logic [31:0]     w_used;
    logic            w_room1, w_room2;
    logic            w_stream;
    logic            w_iss_a, w_iss_b, w_last_a, w_last_b;
    logic            w_idx_iss;
    logic [31:0]     w_idx_ptr;
    logic [31:0]     w_deg;
    logic            w_bad;
    logic            w_fin;
    logic            w_end_cap;

    // Advance a circular FIFO pointer by n (0..2) without assuming a power-of-two depth
    function automatic logic [c_PW-1:0] f_adv(input logic [c_PW-1:0] p, input logic [1:0] n);
        logic [31:0] s;
        s = 32'(p) + 32'(n);
        if (s >= 32'(FIFO_DEPTH)) begin
            s = s - 32'(FIFO_DEPTH);
        end
        return c_PW'(s);
    endfunction

    assign w_idx_tap = idx_pipe_q[MEM_LAT-1];
    assign w_a_tap   = a_pipe_q[MEM_LAT-1];
    assign w_b_tap   = b_pipe_q[MEM_LAT-1];
    assign w_pop     = (count_q != '0) && nbr_ready_in;

    // Buffer slots already promised: stored words plus reads still in the memory pipe
    assign w_used    = 32'(count_q) + 32'(inflight_q);
    assign w_room1   = (w_used + 32'd1) <= 32'(FIFO_DEPTH);
    assign w_room2   = (w_used + 32'd2) <= 32'(FIFO_DEPTH);
    assign w_stream  = (state_q == c_STREAM);
    assign w_iss_b   = w_stream && (rem_q >= 32'd2) && w_room2;
    assign w_iss_a   = w_iss_b || (w_stream && (rem_q == 32'd1) && w_room1);
    assign w_last_a  = w_iss_a && (rem_q == 32'd1);
    assign w_last_b  = w_iss_b && (rem_q == 32'd2);

    assign w_idx_iss = (state_q == c_PTR0) || (state_q == c_PTR1);
    assign w_idx_ptr = (state_q == c_PTR1) ? (vtx_q + 32'd1) : vtx_q;
    assign w_deg     = rowidx_out - start_q;
    assign w_end_cap = (state_q == c_PTR_WAIT) && w_idx_tap && got_start_q;
`ifdef NBR_FETCH_BOUNDS_CHECK_EN
    assign w_bad     = rowidx_out < start_q;
`else
    assign w_bad     = 1'b0;
`endif

    // Last word leaves the buffer this cycle (or already has) with nothing left to fetch
    assign w_fin = (rem_q == 32'd0) && (inflight_q == '0) &&
                   ((count_q == '0) || ((count_q == c_CW'(1)) && w_pop));

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= c_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:     if (vtx_valid_in) state_d = c_PTR0;
            c_PTR0:     state_d = c_PTR1;
            c_PTR1:     state_d = c_PTR_WAIT;
            c_PTR_WAIT: if (w_end_cap) state_d = (w_bad || (w_deg == 32'd0)) ? c_DONE : c_STREAM;
            c_STREAM:   if (w_fin) state_d = c_DONE;
            c_DONE:     state_d = c_IDLE;
            default:    state_d = c_IDLE;
        endcase
    end

    // Output logic: strobes and fresh addresses only in issuing cycles, held addresses otherwise
    always_comb begin
        vtx_ready_out = (state_q == c_IDLE);
        done_out      = (state_q == c_DONE);
        idx_validin   = w_idx_iss;
        idx_addr      = w_idx_iss ? {c_TAG, w_idx_ptr} : idx_addr_q;
        data_validina = w_iss_a;
        data_validinb = w_iss_b;
        data_addra    = w_iss_a ? {c_TAG, e_q} : addra_q;
        data_addrb    = w_iss_b ? {c_TAG, e_q + 32'd1} : addrb_q;
        nbr_valid_out = (count_q != '0);
        nbr_out       = nbr_valid_out ? fifo_mem_q[rd_ptr_q][31:0] : 32'd0;
        nbr_last_out  = nbr_valid_out && fifo_mem_q[rd_ptr_q][32];
        degree_out    = degree_q;
    end

    // Vertex latch, row-pointer capture and degree computation
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            vtx_q       <= 32'd0;
            got_start_q <= 1'b0;
            start_q     <= 32'd0;
            degree_q    <= 32'd0;
        end else begin
            if (state_q == c_IDLE) begin
                got_start_q <= 1'b0;
                if (vtx_valid_in) vtx_q <= vtx_in;
            end else if (w_idx_tap && !got_start_q) begin
                start_q     <= rowidx_out;
                got_start_q <= 1'b1;
            end
            if (w_end_cap) degree_q <= w_bad ? 32'd0 : w_deg;
        end
    end

    // Edge walk: remaining count, next edge index, reads outstanding in the memory
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rem_q      <= 32'd0;
            e_q        <= 32'd0;
            inflight_q <= '0;
        end else begin
            if (w_end_cap) begin
                rem_q <= w_bad ? 32'd0 : w_deg;
                e_q   <= start_q;
            end else begin
                rem_q <= rem_q - 32'(w_iss_a) - 32'(w_iss_b);
                e_q   <= e_q + 32'(w_iss_a) + 32'(w_iss_b);
            end
            inflight_q <= inflight_q + c_CW'(w_iss_a) + c_CW'(w_iss_b)
                                     - c_CW'(w_a_tap) - c_CW'(w_b_tap);
        end
    end

    // Strobe delay lines marking the cycle in which read data is on the bus
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_pipe_q <= '0;
            a_pipe_q   <= '0;
            b_pipe_q   <= '0;
            la_pipe_q  <= '0;
            lb_pipe_q  <= '0;
        end else begin
            for (int i = MEM_LAT - 1; i > 0; i--) begin
                idx_pipe_q[i] <= idx_pipe_q[i-1];
                a_pipe_q[i]   <= a_pipe_q[i-1];
                b_pipe_q[i]   <= b_pipe_q[i-1];
                la_pipe_q[i]  <= la_pipe_q[i-1];
                lb_pipe_q[i]  <= lb_pipe_q[i-1];
            end
            idx_pipe_q[0] <= w_idx_iss;
            a_pipe_q[0]   <= w_iss_a;
            b_pipe_q[0]   <= w_iss_b;
            la_pipe_q[0]  <= w_last_a;
            lb_pipe_q[0]  <= w_last_b;
        end
    end

    // Address hold registers so idle cycles repeat the last issued address
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx_addr_q <= '0;
            addra_q    <= '0;
            addrb_q    <= '0;
        end else begin
            if (w_idx_iss) idx_addr_q <= idx_addr;
            if (w_iss_a)   addra_q    <= data_addra;
            if (w_iss_b)   addrb_q    <= data_addrb;
        end
    end

    // FIFO pointers and occupancy; port A data lands ahead of port B to keep edge order
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= f_adv(wr_ptr_q, {1'b0, w_a_tap} + {1'b0, w_b_tap});
            if (w_pop) rd_ptr_q <= f_adv(rd_ptr_q, 2'd1);
            count_q  <= count_q + c_CW'(w_a_tap) + c_CW'(w_b_tap) - c_CW'(w_pop);
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge clk_in) begin
        if (w_a_tap) fifo_mem_q[wr_ptr_q] <= {la_pipe_q[MEM_LAT-1], data_outa};
        if (w_b_tap) fifo_mem_q[f_adv(wr_ptr_q, {1'b0, w_a_tap})] <= {lb_pipe_q[MEM_LAT-1], data_outb};
    end

`ifdef NBR_FETCH_BOUNDS_CHECK_EN
    logic err_q;

    // Sticky flag for an inverted row-pointer pair
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            err_q <= 1'b0;
        end else if (w_end_cap && w_bad) begin
            err_q <= 1'b1;
        end
    end

    assign err_out = err_q;
`endif

endmodule
`default_nettype wire
